// File: rtl/bram_write_buffer_pkg.sv
// Shared types and helpers for the BRAM write buffer: entry layout and byte-lane merge.
package bram_write_buffer_pkg;

  localparam int LEN_DATA = 32;
  localparam int LEN_ADDR = 8;
  localparam int BYTES    = LEN_DATA / 8;

  typedef struct packed {
    logic [LEN_ADDR-1:0] addr;
    logic [LEN_DATA-1:0] data;
    logic [BYTES-1:0]    strb;
  } wbuf_entry_t;

  function automatic logic [LEN_DATA-1:0] byte_merge(input logic [LEN_DATA-1:0] old_data,
                                                     input logic [LEN_DATA-1:0] new_data,
                                                     input logic [BYTES-1:0]    strb);
    logic [LEN_DATA-1:0] res;
    res = old_data;
    for (int b = 0; b < BYTES; b++) begin
      if (strb[b]) res[b*8 +: 8] = new_data[b*8 +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/wbuf_addr_match.sv
// Combinational probe of all queued entries: hit when any valid entry holds the probe address.
module wbuf_addr_match #(
  parameter int DEPTH    = 4,
  parameter int LEN_ADDR = 8
) (
  input  logic [DEPTH-1:0][LEN_ADDR-1:0] addrs,
  input  logic [DEPTH-1:0]               valid,
  input  logic [LEN_ADDR-1:0]            probe,
  output logic                           hit
);

  always_comb begin
    hit = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid[i] && (addrs[i] == probe)) hit = 1'b1;
    end
  end

endmodule

// File: rtl/bram_write_buffer.sv
// Store queue in front of a byte-write dual-port BRAM: merges same-address stores,
// drains one entry per enabled cycle to port A and holds off port-B reads that would see stale data.
module bram_write_buffer #(
  parameter int LEN_DATA = 32,
  parameter int LEN_ADDR = 8,
  parameter int DEPTH    = 4
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       wr_valid,
  output logic                       wr_ready,
  input  logic [LEN_ADDR-1:0]        wr_addr,
  input  logic [LEN_DATA-1:0]        wr_data,
  input  logic [LEN_DATA/8-1:0]      wr_strb,
  input  logic                       drain_en,
  input  logic                       rd_valid,
  output logic                       rd_ready,
  input  logic [LEN_ADDR-1:0]        rd_addr,
  output logic                       rd_rvalid,
  output logic [LEN_DATA-1:0]        rd_rdata,
  output logic                       bram_ena,
  output logic [LEN_DATA/8-1:0]      bram_wea,
  output logic [LEN_ADDR-1:0]        bram_addra,
  output logic [LEN_DATA-1:0]        bram_dina,
  output logic                       bram_enb,
  output logic [LEN_ADDR-1:0]        bram_addrb,
  input  logic [LEN_DATA-1:0]        bram_doutb,
  output logic [$clog2(DEPTH):0]     count
);
  import bram_write_buffer_pkg::*;

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  wbuf_entry_t                     mem [DEPTH];
  logic [DEPTH-1:0]                valid;
  logic [PW-1:0]                   head;
  logic [PW-1:0]                   tail;
  logic [PW-1:0]                   last;
  logic [DEPTH-1:0][LEN_ADDR-1:0]  addrs;
  logic                            pop;
  logic                            merge_hit;
  logic                            wr_fire;
  logic                            do_merge;
  logic                            do_push;
  logic                            rd_hit;

  assign last = tail - 1'b1;
  assign pop  = (count != '0) && drain_en;

  // The newest entry is only the popping one when it is the sole entry.
  assign merge_hit = (count != '0) && (wr_addr == mem[last].addr) &&
                     !((count == CW'(1)) && drain_en);

  assign wr_ready = (count < CW'(DEPTH)) || merge_hit || ((count == CW'(DEPTH)) && pop);
  assign wr_fire  = wr_valid && wr_ready;
  assign do_merge = wr_fire && (|wr_strb) && merge_hit;
  assign do_push  = wr_fire && (|wr_strb) && !merge_hit;

  assign bram_ena   = pop;
  assign bram_wea   = pop ? mem[head].strb : '0;
  assign bram_addra = mem[head].addr;
  assign bram_dina  = mem[head].data;

  always_comb begin
    for (int i = 0; i < DEPTH; i++) addrs[i] = mem[i].addr;
  end

  wbuf_addr_match #(
    .DEPTH    (DEPTH),
    .LEN_ADDR (LEN_ADDR)
  ) u_rd_match (
    .addrs (addrs),
    .valid (valid),
    .probe (rd_addr),
    .hit   (rd_hit)
  );

  // A popping entry still blocks: the BRAM returns old data on a same-edge read/write collision.
  assign rd_ready   = !(rd_hit || (wr_fire && (wr_addr == rd_addr)));
  assign bram_enb   = rd_valid && rd_ready;
  assign bram_addrb = rd_addr;
  assign rd_rdata   = bram_doutb;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      head      <= '0;
      tail      <= '0;
      count     <= '0;
      valid     <= '0;
      rd_rvalid <= 1'b0;
    end else begin
      if (pop) begin
        head        <= head + 1'b1;
        valid[head] <= 1'b0;
      end
      // At full with a pop, tail equals head; the later set must win.
      if (do_push) begin
        tail        <= tail + 1'b1;
        valid[tail] <= 1'b1;
      end
      count     <= count + CW'(do_push) - CW'(pop);
      rd_rvalid <= bram_enb;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[tail] <= '{addr: wr_addr, data: wr_data, strb: wr_strb};
    end else if (do_merge) begin
      mem[last].data <= byte_merge(mem[last].data, wr_data, wr_strb);
      mem[last].strb <= mem[last].strb | wr_strb;
    end
  end

endmodule

// File: tb/tb_bram_write_buffer.sv
// Directed bench for bram_write_buffer with a behavioural byte-write dual-port BRAM behind it.
module tb_bram_write_buffer;

  logic        clk = 1'b0;
  logic        resetn;
  logic        wr_valid;
  logic        wr_ready;
  logic [7:0]  wr_addr;
  logic [31:0] wr_data;
  logic [3:0]  wr_strb;
  logic        drain_en;
  logic        rd_valid;
  logic        rd_ready;
  logic [7:0]  rd_addr;
  logic        rd_rvalid;
  logic [31:0] rd_rdata;
  logic        bram_ena;
  logic [3:0]  bram_wea;
  logic [7:0]  bram_addra;
  logic [31:0] bram_dina;
  logic        bram_enb;
  logic [7:0]  bram_addrb;
  logic [31:0] bram_doutb;
  logic [2:0]  count;

  int errors = 0;
  int checks = 0;

  logic [31:0] bmem [256];

  always #5 clk = ~clk;

  bram_write_buffer dut (
    .clk        (clk),
    .resetn     (resetn),
    .wr_valid   (wr_valid),
    .wr_ready   (wr_ready),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .wr_strb    (wr_strb),
    .drain_en   (drain_en),
    .rd_valid   (rd_valid),
    .rd_ready   (rd_ready),
    .rd_addr    (rd_addr),
    .rd_rvalid  (rd_rvalid),
    .rd_rdata   (rd_rdata),
    .bram_ena   (bram_ena),
    .bram_wea   (bram_wea),
    .bram_addra (bram_addra),
    .bram_dina  (bram_dina),
    .bram_enb   (bram_enb),
    .bram_addrb (bram_addrb),
    .bram_doutb (bram_doutb),
    .count      (count)
  );

  always @(posedge clk) begin
    if (bram_ena) begin
      for (int b = 0; b < 4; b++)
        if (bram_wea[b]) bmem[bram_addra][b*8 +: 8] <= bram_dina[b*8 +: 8];
    end
    if (bram_enb) bram_doutb <= bmem[bram_addrb];
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    resetn = 1'b0; wr_valid = 0; wr_addr = 0; wr_data = 0; wr_strb = 0;
    drain_en = 0; rd_valid = 0; rd_addr = 0;
    #12;
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL reset_count got %0d want 0", count); end
    checks++; if (bram_ena !== 1'b0) begin errors++; $display("FAIL reset_ena got %b want 0", bram_ena); end
    checks++; if (bram_wea !== 4'b0) begin errors++; $display("FAIL reset_wea got %b want 0000", bram_wea); end
    checks++; if (bram_enb !== 1'b0) begin errors++; $display("FAIL reset_enb got %b want 0", bram_enb); end
    checks++; if (rd_rvalid !== 1'b0) begin errors++; $display("FAIL reset_rvalid got %b want 0", rd_rvalid); end
    checks++; if (rd_ready !== 1'b1) begin errors++; $display("FAIL reset_rd_ready got %b want 1", rd_ready); end
    checks++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL reset_wr_ready got %b want 1", wr_ready); end
    resetn = 1'b1;
    step();
  endtask

  task automatic test_single_store();
    wr_valid = 1; wr_addr = 8'h10; wr_data = 32'hAABBCCDD; wr_strb = 4'b1111;
    step();
    wr_valid = 0;
    #1;
    checks++; if (count !== 3'd1) begin errors++; $display("FAIL single_count got %0d want 1", count); end
    checks++; if (bram_ena !== 1'b0) begin errors++; $display("FAIL single_ena_idle got %b want 0", bram_ena); end
    drain_en = 1;
    #1;
    checks++; if (bram_ena !== 1'b1) begin errors++; $display("FAIL single_ena got %b want 1", bram_ena); end
    checks++; if (bram_addra !== 8'h10) begin errors++; $display("FAIL single_addra got %h want 10", bram_addra); end
    checks++; if (bram_dina !== 32'hAABBCCDD) begin errors++; $display("FAIL single_dina got %h want aabbccdd", bram_dina); end
    step();
    drain_en = 0;
    #1;
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL single_drained got %0d want 0", count); end
    rd_valid = 1; rd_addr = 8'h10;
    #1;
    checks++; if (rd_ready !== 1'b1) begin errors++; $display("FAIL single_rd_ready got %b want 1", rd_ready); end
    step();
    rd_valid = 0;
    #1;
    checks++; if (rd_rvalid !== 1'b1) begin errors++; $display("FAIL single_rvalid got %b want 1", rd_rvalid); end
    checks++; if (rd_rdata !== 32'hAABBCCDD) begin errors++; $display("FAIL single_rdata got %h want aabbccdd", rd_rdata); end
    step();
    checks++; if (rd_rvalid !== 1'b0) begin errors++; $display("FAIL single_rvalid_drop got %b want 0", rd_rvalid); end
  endtask

  task automatic test_merge();
    wr_valid = 1; wr_addr = 8'h20; wr_data = 32'h11223344; wr_strb = 4'b0011;
    step();
    wr_data = 32'h55667788; wr_strb = 4'b1100;
    #1;
    checks++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL merge_wr_ready got %b want 1", wr_ready); end
    step();
    wr_valid = 0;
    #1;
    checks++; if (count !== 3'd1) begin errors++; $display("FAIL merge_count got %0d want 1", count); end
    drain_en = 1;
    #1;
    checks++; if (bram_wea !== 4'b1111) begin errors++; $display("FAIL merge_wea got %b want 1111", bram_wea); end
    checks++; if (bram_dina !== 32'h55663344) begin errors++; $display("FAIL merge_dina got %h want 55663344", bram_dina); end
    step();
    drain_en = 0;
    #1;
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL merge_drained got %0d want 0", count); end
  endtask

  task automatic test_full();
    logic [7:0] exp_a [4];
    exp_a = '{8'h01, 8'h02, 8'h03, 8'h06};
    for (int i = 0; i < 4; i++) begin
      wr_valid = 1; wr_addr = 8'(i); wr_data = 32'hC0DE0000 + i; wr_strb = 4'b1111;
      step();
    end
    wr_valid = 0;
    #1;
    checks++; if (count !== 3'd4) begin errors++; $display("FAIL full_count got %0d want 4", count); end
    wr_valid = 1; wr_addr = 8'h05;
    #1;
    checks++; if (wr_ready !== 1'b0) begin errors++; $display("FAIL full_block got %b want 0", wr_ready); end
    wr_addr = 8'h03;
    #1;
    checks++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL full_merge_ready got %b want 1", wr_ready); end
    wr_addr = 8'h06; drain_en = 1;
    #1;
    checks++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL full_poppush_ready got %b want 1", wr_ready); end
    checks++; if (bram_addra !== 8'h00) begin errors++; $display("FAIL full_head got %h want 00", bram_addra); end
    step();
    wr_valid = 0;
    #1;
    checks++; if (count !== 3'd4) begin errors++; $display("FAIL full_poppush_count got %0d want 4", count); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (bram_addra !== exp_a[i]) begin errors++; $display("FAIL full_order%0d got %h want %h", i, bram_addra, exp_a[i]); end
      step();
    end
    drain_en = 0;
    #1;
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL full_empty got %0d want 0", count); end
  endtask

  task automatic test_read_hazard();
    wr_valid = 1; wr_addr = 8'h40; wr_data = 32'hDEADBEEF; wr_strb = 4'b1111;
    step();
    wr_valid = 0;
    rd_valid = 1; rd_addr = 8'h41;
    #1;
    checks++; if (rd_ready !== 1'b1) begin errors++; $display("FAIL hz_other_ready got %b want 1", rd_ready); end
    step();
    rd_addr = 8'h40;
    #1;
    checks++; if (rd_rvalid !== 1'b1) begin errors++; $display("FAIL hz_other_rvalid got %b want 1", rd_rvalid); end
    checks++; if (rd_ready !== 1'b0) begin errors++; $display("FAIL hz_block got %b want 0", rd_ready); end
    step();
    checks++; if (rd_ready !== 1'b0) begin errors++; $display("FAIL hz_block2 got %b want 0", rd_ready); end
    checks++; if (bram_enb !== 1'b0) begin errors++; $display("FAIL hz_enb got %b want 0", bram_enb); end
    drain_en = 1;
    #1;
    checks++; if (rd_ready !== 1'b0) begin errors++; $display("FAIL hz_popping got %b want 0", rd_ready); end
    step();
    drain_en = 0;
    #1;
    checks++; if (rd_ready !== 1'b1) begin errors++; $display("FAIL hz_release got %b want 1", rd_ready); end
    step();
    rd_valid = 0;
    #1;
    checks++; if (rd_rvalid !== 1'b1) begin errors++; $display("FAIL hz_rvalid got %b want 1", rd_rvalid); end
    checks++; if (rd_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL hz_rdata got %h want deadbeef", rd_rdata); end
    wr_valid = 1; wr_addr = 8'h41; rd_valid = 1; rd_addr = 8'h41;
    #1;
    checks++; if (rd_ready !== 1'b0) begin errors++; $display("FAIL hz_same_cycle got %b want 0", rd_ready); end
    wr_valid = 0; rd_valid = 0;
    #1;
  endtask

  task automatic test_zero_strb_and_reset();
    wr_valid = 1; wr_addr = 8'h50; wr_data = 32'h12345678; wr_strb = 4'b0000;
    #1;
    checks++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL zs_ready got %b want 1", wr_ready); end
    step();
    #1;
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL zs_count got %0d want 0", count); end
    wr_strb = 4'b1111;
    for (int i = 0; i < 3; i++) begin
      wr_addr = 8'h60 + 8'(i);
      if (i == 2) begin rd_valid = 1; rd_addr = 8'h70; end
      step();
    end
    wr_valid = 0; rd_valid = 0; drain_en = 1;
    #1;
    checks++; if (count !== 3'd3) begin errors++; $display("FAIL rst_pre_count got %0d want 3", count); end
    checks++; if (rd_rvalid !== 1'b1) begin errors++; $display("FAIL rst_pre_rvalid got %b want 1", rd_rvalid); end
    checks++; if (bram_ena !== 1'b1) begin errors++; $display("FAIL rst_pre_ena got %b want 1", bram_ena); end
    resetn = 1'b0;
    #1;
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL rst_count got %0d want 0", count); end
    checks++; if (bram_ena !== 1'b0) begin errors++; $display("FAIL rst_ena got %b want 0", bram_ena); end
    checks++; if (rd_rvalid !== 1'b0) begin errors++; $display("FAIL rst_rvalid got %b want 0", rd_rvalid); end
    #1;
    resetn = 1'b1; drain_en = 0;
    #1;
    checks++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL rst_wr_ready got %b want 1", wr_ready); end
    step();
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL rst_post_count got %0d want 0", count); end
  endtask

  initial begin
    test_reset();
    test_single_store();
    test_merge();
    test_full();
    test_read_hazard();
    test_zero_strb_and_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
